// File: rtl/fpu_to_int.sv
// rtl/fpu_to_int.sv - float32 (1/11/20) to signed int32 converter, one shift per cycle; optional ROUND_NEAREST_EN
package fpu_to_int_pkg;
  typedef enum logic [1:0] {
    EXACT     = 2'd0,
    INEXACT   = 2'd1,
    UNDERFLOW = 2'd2,
    OVERFLOW  = 2'd3
  } g_eStatus;
endpackage

module fpu_to_int
  import fpu_to_int_pkg::*;
#(
  parameter int BIAS     = 1023,
  parameter bit SATURATE = 1'b1
) (
  input  logic        m_clk,
  input  logic        m_reset,
  input  logic        m_start,
  input  logic [31:0] m_opA,
  output logic        m_busy,
  output logic        m_done,
  output logic [31:0] m_dataOut,
  output g_eStatus    m_statusOut
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FINAL} state_t;

  localparam logic signed [12:0] BIAS_S  = 13'(BIAS);
  localparam logic [31:0]        POS_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0]        NEG_MAX = 32'h8000_0000;
`ifdef ROUND_NEAREST_EN
  localparam logic signed [12:0] E_MIN = -13'sd1;
`else
  localparam logic signed [12:0] E_MIN = 13'sd0;
`endif

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] wrk_q, wrk_d;
  logic [4:0]  n_q, n_d;
  logic        left_q, left_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic        special_q, special_d;
  g_eStatus    sp_stat_q, sp_stat_d;
  logic [31:0] data_q, data_d;
  g_eStatus    status_q, status_d;
  logic        done_q, done_d;

  logic              sign;
  logic [10:0]       exp_f;
  logic [19:0]       mant;
  logic signed [12:0] e_s;
  logic [31:0]       sat_val;

  // Decode the captured operand into sign, unbiased exponent and the out-of-range value
  always_comb begin
    sign    = op_q[31];
    exp_f   = op_q[30:20];
    mant    = op_q[19:0];
    e_s     = $signed({2'b00, exp_f}) - BIAS_S;
    sat_val = SATURATE ? (sign ? NEG_MAX : POS_MAX) : 32'h0;
  end

  logic [32:0] mag;
  logic [31:0] res;
  logic        ovf_r;

  // Final magnitude (optionally rounded before negation) and the signed result
  always_comb begin
    mag   = {1'b0, wrk_q};
    ovf_r = 1'b0;
`ifdef ROUND_NEAREST_EN
    if (guard_q && (sticky_q || wrk_q[0])) mag = mag + 33'd1;
    ovf_r = sign ? (mag > {1'b0, NEG_MAX}) : (mag > {1'b0, POS_MAX});
`endif
    res = sign ? (32'd0 - mag[31:0]) : mag[31:0];
  end

  // Next-state and datapath for IDLE -> LOAD -> SHIFT -> FINAL
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wrk_d     = wrk_q;
    n_d       = n_q;
    left_d    = left_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    special_d = special_q;
    sp_stat_d = sp_stat_q;
    data_d    = data_q;
    status_d  = status_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m_start) begin
          op_d    = m_opA;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wrk_d     = {11'd0, 1'b1, mant};
        n_d       = 5'd0;
        left_d    = 1'b0;
        guard_d   = 1'b0;
        sticky_d  = 1'b0;
        special_d = 1'b1;
        sp_stat_d = EXACT;
        state_d   = S_FINAL;
        if (exp_f == 11'd0) begin
          // Zero and denormals both flush to 0
          wrk_d     = 32'd0;
          sp_stat_d = (mant == 20'd0) ? EXACT : UNDERFLOW;
        end else if (exp_f == 11'h7FF || e_s > 13'sd31 ||
                     (e_s == 13'sd31 && (!sign || mant != 20'd0))) begin
          wrk_d     = sat_val;
          sp_stat_d = OVERFLOW;
        end else if (e_s == 13'sd31) begin
          // -2^31 is the only representable value at e=31
          wrk_d = NEG_MAX;
        end else if (e_s < E_MIN) begin
          wrk_d     = 32'd0;
          sp_stat_d = UNDERFLOW;
        end else begin
          special_d = 1'b0;
          if (e_s > 13'sd20) begin
            left_d = 1'b1;
            n_d    = 5'(e_s - 13'sd20);
          end else begin
            n_d = 5'(13'sd20 - e_s);
          end
          if (n_d != 5'd0) state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          wrk_d = {wrk_q[30:0], 1'b0};
        end else begin
          wrk_d    = {1'b0, wrk_q[31:1]};
          guard_d  = wrk_q[0];
          sticky_d = sticky_q | guard_q;
        end
        n_d = n_q - 5'd1;
        if (n_q == 5'd1) state_d = S_FINAL;
      end
      S_FINAL: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (special_q) begin
          data_d   = wrk_q;
          status_d = sp_stat_q;
        end else if (ovf_r) begin
          data_d   = sat_val;
          status_d = OVERFLOW;
        end else begin
          data_d   = res;
          status_d = (res == 32'd0)        ? UNDERFLOW :
                     (guard_q || sticky_q) ? INEXACT   : EXACT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge m_clk or negedge m_reset) begin
    if (!m_reset) begin
      state_q   <= S_IDLE;
      op_q      <= 32'd0;
      wrk_q     <= 32'd0;
      n_q       <= 5'd0;
      left_q    <= 1'b0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      special_q <= 1'b0;
      sp_stat_q <= EXACT;
      data_q    <= 32'd0;
      status_q  <= EXACT;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wrk_q     <= wrk_d;
      n_q       <= n_d;
      left_q    <= left_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      special_q <= special_d;
      sp_stat_q <= sp_stat_d;
      data_q    <= data_d;
      status_q  <= status_d;
      done_q    <= done_d;
    end
  end

  assign m_busy      = (state_q != S_IDLE);
  assign m_done      = done_q;
  assign m_dataOut   = data_q;
  assign m_statusOut = status_q;

endmodule

// File: tb/tb_fpu_to_int.sv
// tb/tb_fpu_to_int.sv - randomized self-checking bench for fpu_to_int against an arithmetic reference model
module tb_fpu_to_int;
  import fpu_to_int_pkg::*;

  logic        m_clk = 1'b0;
  logic        m_reset = 1'b0;
  logic        m_start = 1'b0;
  logic [31:0] m_opA = 32'd0;

  logic        busy1, done1, busy0, done0;
  logic [31:0] data1, data0;
  g_eStatus    stat1, stat0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] op;
    logic [31:0] d_sat;
    logic [31:0] d_zero;
    g_eStatus    st;
    int          lat;
    int          elapsed;
  } exp_t;

  exp_t        pend[$];
  logic [31:0] hold1 = 32'd0;
  logic [31:0] hold0 = 32'd0;
  g_eStatus    hold_st = EXACT;

  fpu_to_int #(.BIAS(1023), .SATURATE(1'b1)) dut_sat (
    .m_clk(m_clk), .m_reset(m_reset), .m_start(m_start), .m_opA(m_opA),
    .m_busy(busy1), .m_done(done1), .m_dataOut(data1), .m_statusOut(stat1)
  );

  fpu_to_int #(.BIAS(1023), .SATURATE(1'b0)) dut_zero (
    .m_clk(m_clk), .m_reset(m_reset), .m_start(m_start), .m_opA(m_opA),
    .m_busy(busy0), .m_done(done0), .m_dataOut(data0), .m_statusOut(stat0)
  );

  always #5 m_clk = ~m_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, req);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Reference: value = (-1)^s * 1.mant * 2^(exp-1023), converted by exact integer arithmetic
  function automatic void model(input logic [31:0] op, output logic [31:0] ds,
                                output logic [31:0] dz, output g_eStatus st, output int lat);
    bit     s;
    int     ex, e;
    longint sig, mag, rem, half, val;
    s   = op[31];
    ex  = int'(op[30:20]);
    e   = ex - 1023;
    sig = longint'({1'b1, op[19:0]});
    ds  = 32'd0;
    dz  = 32'd0;
    st  = EXACT;
    lat = 2;
    if (ex == 0) begin
      st = (op[19:0] == 20'd0) ? EXACT : UNDERFLOW;
      return;
    end
    if (ex == 2047 || e > 31) begin
      ds = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      st = OVERFLOW;
      return;
    end
    if (e >= 20) begin
      mag = sig << (e - 20);
      rem = 0;
      half = 1;
    end else if (e < -40) begin
      mag = 0;
      rem = 1;
      half = 2;
    end else begin
      mag  = sig >>> (20 - e);
      rem  = sig & ((64'sd1 << (20 - e)) - 1);
      half = 64'sd1 << (19 - e);
    end
`ifdef ROUND_NEAREST_EN
    if (rem > half || (rem == half && mag[0])) mag = mag + 1;
`endif
    if ((!s && mag > 64'sd2147483647) || (s && mag > 64'sd2147483648)) begin
      ds = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      st = OVERFLOW;
      return;
    end
    val = s ? -mag : mag;
    ds  = val[31:0];
    dz  = ds;
    st  = (ds == 32'd0) ? UNDERFLOW : (rem != 0) ? INEXACT : EXACT;
    if (e >= 0 && e <= 20) lat = 22 - e;
    else if (e >= 21 && e <= 30) lat = e - 18;
`ifdef ROUND_NEAREST_EN
    else if (e == -1) lat = 23;
`endif
  endfunction

  // Cycle-by-cycle check of both instances against the model and held outputs
  initial begin
    exp_t c;
    forever begin
      @(posedge m_clk);
      #1;
      if (pend.size() > 0) begin
        c = pend[0];
        if (c.elapsed == c.lat) begin
          chk($sformatf("done1 op=%08h", c.op), 32'(done1), 32'd1);
          chk($sformatf("busy1_end op=%08h", c.op), 32'(busy1), 32'd0);
          chk($sformatf("data_sat op=%08h", c.op), data1, c.d_sat);
          chk($sformatf("status_sat op=%08h", c.op), 32'(stat1), 32'(c.st));
          chk($sformatf("done0 op=%08h", c.op), 32'(done0), 32'd1);
          chk($sformatf("data_zero op=%08h", c.op), data0, c.d_zero);
          chk($sformatf("status_zero op=%08h", c.op), 32'(stat0), 32'(c.st));
          hold1   = c.d_sat;
          hold0   = c.d_zero;
          hold_st = c.st;
          void'(pend.pop_front());
        end else begin
          chk($sformatf("busy1 op=%08h t=%0d", c.op, c.elapsed), 32'(busy1), 32'd1);
          chk($sformatf("done1_early op=%08h t=%0d", c.op, c.elapsed), 32'(done1), 32'd0);
          chk($sformatf("busy0 op=%08h t=%0d", c.op, c.elapsed), 32'(busy0), 32'd1);
          chk($sformatf("held_data op=%08h", c.op), data1, hold1);
          chk($sformatf("held_status op=%08h", c.op), 32'(stat1), 32'(hold_st));
          c.elapsed = c.elapsed + 1;
          pend[0] = c;
        end
      end else begin
        chk("idle_busy", 32'(busy1), 32'd0);
        chk("idle_done", 32'(done1), 32'd0);
        chk("idle_busy0", 32'(busy0), 32'd0);
        chk("idle_data", data1, hold1);
        chk("idle_data0", data0, hold0);
        chk("idle_status", 32'(stat1), 32'(hold_st));
      end
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge m_clk);
    while ((busy1 !== 1'b0 || pend.size() != 0) && w < 200) begin
      @(negedge m_clk);
      w++;
    end
    if (w >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: busy still %0b after %0d cycles", busy1, w);
      summary_and_finish();
    end
  endtask

  task automatic issue(input logic [31:0] op);
    exp_t e;
    wait_idle();
    model(op, e.d_sat, e.d_zero, e.st, e.lat);
    e.op      = op;
    e.elapsed = 0;
    pend.push_back(e);
    m_opA   = op;
    m_start = 1'b1;
    @(negedge m_clk);
    m_start = 1'b0;
    m_opA   = $urandom;
  endtask

  logic [31:0] pin_op  [10];
  logic [31:0] pin_ds  [10];
  logic [31:0] pin_dz  [10];
  g_eStatus    pin_st  [10];
  int          pin_lat [10];

  initial begin
    logic [31:0] ds, dz, rop;
    g_eStatus    st;
    int          lat, k;
    logic [10:0] rexp;
    logic [19:0] rmant;

    pin_op[0] = 32'h3FF0_0000; pin_ds[0] = 32'h0000_0001; pin_dz[0] = 32'h0000_0001; pin_st[0] = EXACT;     pin_lat[0] = 22;
    pin_op[1] = 32'hC004_0000; pin_ds[1] = 32'hFFFF_FFFE; pin_dz[1] = 32'hFFFF_FFFE; pin_st[1] = INEXACT;   pin_lat[1] = 21;
`ifdef ROUND_NEAREST_EN
    pin_op[2] = 32'h3FE8_0000; pin_ds[2] = 32'h0000_0001; pin_dz[2] = 32'h0000_0001; pin_st[2] = INEXACT;   pin_lat[2] = 23;
    pin_op[9] = 32'h3FE0_0000; pin_ds[9] = 32'h0000_0000; pin_dz[9] = 32'h0000_0000; pin_st[9] = UNDERFLOW; pin_lat[9] = 23;
`else
    pin_op[2] = 32'h3FE8_0000; pin_ds[2] = 32'h0000_0000; pin_dz[2] = 32'h0000_0000; pin_st[2] = UNDERFLOW; pin_lat[2] = 2;
    pin_op[9] = 32'h4001_0000; pin_ds[9] = 32'h0000_0002; pin_dz[9] = 32'h0000_0002; pin_st[9] = INEXACT;   pin_lat[9] = 21;
`endif
    pin_op[3] = 32'h41D0_0001; pin_ds[3] = 32'h4000_0400; pin_dz[3] = 32'h4000_0400; pin_st[3] = EXACT;     pin_lat[3] = 12;
    pin_op[4] = 32'h41E0_0000; pin_ds[4] = 32'h7FFF_FFFF; pin_dz[4] = 32'h0000_0000; pin_st[4] = OVERFLOW;  pin_lat[4] = 2;
    pin_op[5] = 32'hC1E0_0000; pin_ds[5] = 32'h8000_0000; pin_dz[5] = 32'h8000_0000; pin_st[5] = EXACT;     pin_lat[5] = 2;
    pin_op[6] = 32'h7FF0_0000; pin_ds[6] = 32'h7FFF_FFFF; pin_dz[6] = 32'h0000_0000; pin_st[6] = OVERFLOW;  pin_lat[6] = 2;
    pin_op[7] = 32'h0001_2345; pin_ds[7] = 32'h0000_0000; pin_dz[7] = 32'h0000_0000; pin_st[7] = UNDERFLOW; pin_lat[7] = 2;
    pin_op[8] = 32'hC1E0_0001; pin_ds[8] = 32'h8000_0000; pin_dz[8] = 32'h0000_0000; pin_st[8] = OVERFLOW;  pin_lat[8] = 2;

    for (int i = 0; i < 10; i++) begin
      model(pin_op[i], ds, dz, st, lat);
      chk($sformatf("pin_ds %08h", pin_op[i]), ds, pin_ds[i]);
      chk($sformatf("pin_dz %08h", pin_op[i]), dz, pin_dz[i]);
      chk($sformatf("pin_st %08h", pin_op[i]), 32'(st), 32'(pin_st[i]));
      chk($sformatf("pin_lat %08h", pin_op[i]), 32'(lat), 32'(pin_lat[i]));
    end

    repeat (3) @(negedge m_clk);
    chk("reset_busy", 32'(busy1), 32'd0);
    chk("reset_done", 32'(done1), 32'd0);
    chk("reset_data", data1, 32'd0);
    chk("reset_status", 32'(stat1), 32'(EXACT));
    m_reset = 1'b1;

    for (int i = 0; i < 10; i++) issue(pin_op[i]);

    // A start while busy must be dropped, not queued
    issue(32'h3FF0_0000);
    repeat (4) @(negedge m_clk);
    m_opA   = 32'h4000_0000;
    m_start = 1'b1;
    @(negedge m_clk);
    m_start = 1'b0;
    wait_idle();
    repeat (3) @(negedge m_clk);

    // Reset mid-conversion: outputs clear at once and no done follows
    issue(32'h3FF0_0000);
    repeat (9) @(negedge m_clk);
    m_reset = 1'b0;
    pend.delete();
    hold1   = 32'd0;
    hold0   = 32'd0;
    hold_st = EXACT;
    #1;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_data", data1, 32'd0);
    chk("abort_status", 32'(stat1), 32'(EXACT));
    repeat (3) @(negedge m_clk);
    m_reset = 1'b1;
    issue(32'h41D0_0001);

    for (int i = 0; i < 200; i++) begin
      k     = int'($urandom_range(0, 9));
      rmant = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom);
      if (k < 7)       rexp = 11'(1020 + $urandom_range(0, 36));
      else if (k == 7) rexp = 11'($urandom);
      else if (k == 8) rexp = $urandom_range(0, 1) ? 11'h7FF : 11'd0;
      else begin
        case ($urandom_range(0, 3))
          0:       rexp = 11'd1022;
          1:       rexp = 11'd1043;
          2:       rexp = 11'd1053;
          default: rexp = 11'd1054;
        endcase
      end
      rop = {1'($urandom), rexp, rmant};
      issue(rop);
    end

    wait_idle();
    repeat (3) @(negedge m_clk);
    summary_and_finish();
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_to_int.md
Name: fpu_to_int

Overview:
- Sequential converter from the FPU's 32-bit float format to a two's-complement signed 32-bit integer.
- Float format: sign[31], exponent[30:20] (11 bits, biased), mantissa[19:0] (20 bits, hidden leading 1).
- Sits downstream of the FPU adder and decodes its result words back into integers for the datapath.
- Shifts one bit per cycle under a small FSM, with a start/busy/done handshake and a g_eStatus status output.

Parameters:
- BIAS, 1023, exponent bias; value = (-1)^s * 1.mant * 2^(exp-BIAS).
- SATURATE, 1, out-of-range behaviour: 1 clamps to 0x7FFFFFFF / 0x80000000; 0 forces 0x00000000.

Ports:
- m_clk  in  1  clock; all state changes on the rising edge.
- m_reset  in  1  asynchronous, active-low reset.
- m_start  in  1  request pulse; sampled only in IDLE.
- m_opA  in  32  float operand; captured on the edge where m_start is accepted.
- m_busy  out  1  high from the accept edge until done.
- m_done  out  1  one-cycle pulse; m_dataOut and m_statusOut are valid from this cycle on.
- m_dataOut  out  32  signed integer result; held until the next completion.
- m_statusOut  out  g_eStatus  EXACT / INEXACT / UNDERFLOW / OVERFLOW; held with m_dataOut.

Behaviour:
- Reset, on m_reset low, asynchronous: state=IDLE, m_busy=0, m_done=0, m_dataOut=0, m_statusOut=EXACT. Reset mid-conversion aborts it with no done pulse.
- FSM states: IDLE -> LOAD -> SHIFT -> FINAL -> IDLE.
- IDLE: when m_start=1, capture m_opA and go to LOAD; m_busy rises.
- LOAD:
  - Form sig = {1, mant} (21 bits) and e = exp - BIAS, computed signed, width ≥ 12.
  - Load shift counter n: e in 0..20 gives right shift n = 20-e; e in 21..30 gives left shift n = e-20.
  - Special cases go straight to FINAL with n=0.
  - Extend the working register to 32 bits.
- Special cases, in priority order:
  - exp=0: result 0; EXACT if mant=0, else UNDERFLOW (denormals flushed).
  - exp=all ones, or e>31, or e=31 with (sign=0 or mant≠0): OVERFLOW, output per SATURATE and sign.
  - e=31, sign=1, mant=0: result 0x80000000, EXACT.
  - e<0: result 0, UNDERFLOW.
- SHIFT:
  - One bit per cycle; n decrements each cycle; exit to FINAL when n reaches 0.
  - Right shifts keep a guard bit (last bit shifted out) and a sticky bit (OR of all earlier shifted-out bits).
  - Left shifts never lose bits (e ≤ 30 keeps the magnitude below 2^31).
- FINAL:
  - Truncate toward zero.
  - Negate if sign=1.
  - Set status: INEXACT if guard|sticky, else EXACT; UNDERFLOW if the input is nonzero and the result is 0.
  - Register outputs, pulse m_done for one cycle, drop m_busy, return to IDLE.
- Latency: start accepted at edge 0; m_done is high after edge n+2 (n=0 for special cases).
- m_start while busy: ignored, never queued. A new start may be accepted in the cycle m_done is high, since the FSM is already back in IDLE.
- Status precedence: OVERFLOW > UNDERFLOW > INEXACT > EXACT.

Optional Feature:
- Macro: ROUND_NEAREST_EN.
- Defined:
  - FINAL rounds to nearest, ties to even, using guard, sticky and result LSB; the increment is applied to the magnitude before negation.
  - e=-1 takes the shift path with n=21 instead of the UNDERFLOW special case.
  - If rounding pushes the magnitude past 2^31-1 (positive) or 2^31 (negative), status is OVERFLOW with saturation.
- Undefined: truncation toward zero only; the rounding logic is not compiled.

Test Plan:
1. m_opA=0x3FF00000 (1.0) -> after 22 edges m_done=1, m_dataOut=0x00000001, EXACT; m_busy high for 22 cycles.
2. m_opA=0xC0040000 (-2.5) -> m_dataOut=0xFFFFFFFE (-2), INEXACT; with ROUND_NEAREST_EN also -2 (tie to even), INEXACT.
3. m_opA=0x3FE80000 (0.75) -> 0x00000000, UNDERFLOW; with ROUND_NEAREST_EN 0x00000001, INEXACT after 23 edges.
4. m_opA=0x41D00001 (e=30) -> 10 left shifts, done after 12 edges, 0x40000400, EXACT.
5. Range boundaries:
   - 0x41E00000 -> 0x7FFFFFFF, OVERFLOW (SATURATE=0 gives 0x00000000).
   - 0xC1E00000 -> 0x80000000, EXACT.
   - 0x7FF00000 -> OVERFLOW.
   - 0x00012345 -> 0, UNDERFLOW after 2 edges.
6. Control:
   - Start 1.0, pulse m_start with 0x40000000 at edge 5 -> ignored, first result only.
   - Assert m_reset low at edge 10 -> outputs 0/EXACT immediately, no m_done; next start completes normally.
